// File: rtl/text_mode_pkg.sv
// Shared cell layout and field widths for the text-mode display pipeline.
package text_mode_pkg;

   localparam int CELL_W   = 16;
   localparam int CODE_W   = 8;
   localparam int COLOR_W  = 4;
   localparam int CODE_LSB = 0;
   localparam int FG_LSB   = 8;
   localparam int BG_LSB   = 12;

   typedef struct packed {
      logic [COLOR_W-1:0] bg;
      logic [COLOR_W-1:0] fg;
      logic [CODE_W-1:0]  code;
   } cell_t;

endpackage

// File: rtl/cursor_blink.sv
// Counts vsync rising edges and toggles the cursor blink phase every BLINK_FRAMES frames.
module cursor_blink #(
   parameter int BLINK_FRAMES = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic vsync,
   output logic phase
);

   localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic          vsync_prev_reg;
   logic [CW-1:0] count_reg;
   logic          phase_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vsync_prev_reg <= 1'b0;
         count_reg      <= '0;
         phase_reg      <= 1'b0;
      end else begin
         vsync_prev_reg <= vsync;
         // A vsync held high is one frame; only the low-to-high transition counts.
         if (vsync && !vsync_prev_reg) begin
            if (count_reg == CW'(BLINK_FRAMES - 1)) begin
               count_reg <= '0;
               phase_reg <= ~phase_reg;
            end else begin
               count_reg <= count_reg + 1'b1;
            end
         end
      end
   end

   assign phase = phase_reg;

endmodule

// File: rtl/text_mode_ctrl.sv
// Three-stage text-mode pixel pipeline: cell fetch, glyph-row fetch, bit select and colour,
// with matching sync delay and a blinking hardware cursor.
module text_mode_ctrl
   import text_mode_pkg::*;
#(
   parameter int FONT_WIDTH   = 8,
   parameter int FONT_HEIGHT  = 16,
   parameter int N_CHARS      = 256,
   parameter int COLS         = 80,
   parameter int ROWS         = 30,
   parameter int HW           = 10,
   parameter int BLINK_FRAMES = 32,
   parameter int CURSOR_START = 14
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [HW-1:0]                  hcount,
   input  logic [HW-1:0]                  vcount,
   input  logic                           active_in,
   input  logic                           hsync_in,
   input  logic                           vsync_in,
   input  logic                           enable,
   input  logic                           cursor_en,
   input  logic [$clog2(COLS)-1:0]        cursor_col,
   input  logic [$clog2(ROWS)-1:0]        cursor_row,
   output logic [$clog2(COLS*ROWS)-1:0]   cell_addr,
   input  logic [CELL_W-1:0]              cell_data,
   output logic [$clog2(N_CHARS)-1:0]     codepoint,
   output logic [$clog2(FONT_HEIGHT)-1:0] glyph_row,
   input  logic [FONT_WIDTH-1:0]          bitmap_row,
   output logic [COLOR_W-1:0]             pixel,
   output logic                           active_out,
   output logic                           hsync_out,
   output logic                           vsync_out
);

   localparam int CP_W   = $clog2(N_CHARS);
   localparam int GR_W   = $clog2(FONT_HEIGHT);
   localparam int FC_W   = $clog2(FONT_WIDTH);
   localparam int COL_W  = $clog2(COLS);
   localparam int ROW_W  = $clog2(ROWS);
   localparam int ADDR_W = $clog2(COLS*ROWS);

   logic blink_phase;

   cursor_blink #(
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_cursor_blink (
      .clk   (clk),
      .rst_n (rst_n),
      .vsync (vsync_in),
      .phase (blink_phase)
   );

   // Stage 0: cell address and cursor hit from the raster counters.
   logic [HW-1:0]     cell_x;
   logic [HW-1:0]     cell_y;
   logic [ADDR_W-1:0] lin_addr;
   logic              col_ok;
   logic              row_ok;
   logic              hit_s0;

   assign cell_x    = hcount >> FC_W;
   assign cell_y    = vcount >> GR_W;
   assign lin_addr  = ADDR_W'(cell_y) * ADDR_W'(COLS) + ADDR_W'(cell_x);
   assign cell_addr = active_in ? lin_addr : '0;

   assign col_ok = ({1'b0, cursor_col} < (COL_W+1)'(COLS)) && (cell_x == HW'(cursor_col));
   assign row_ok = ({1'b0, cursor_row} < (ROW_W+1)'(ROWS)) && (cell_y == HW'(cursor_row));
   assign hit_s0 = cursor_en && !blink_phase && col_ok && row_ok;

   logic [FC_W-1:0] col_s1_reg;
   logic [GR_W-1:0] row_s1_reg;
   logic            active_s1_reg, hsync_s1_reg, vsync_s1_reg, hit_s1_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col_s1_reg    <= '0;
         row_s1_reg    <= '0;
         active_s1_reg <= 1'b0;
         hsync_s1_reg  <= 1'b0;
         vsync_s1_reg  <= 1'b0;
         hit_s1_reg    <= 1'b0;
      end else begin
         col_s1_reg    <= hcount[FC_W-1:0];
         row_s1_reg    <= vcount[GR_W-1:0];
         active_s1_reg <= active_in;
         hsync_s1_reg  <= hsync_in;
         vsync_s1_reg  <= vsync_in;
         hit_s1_reg    <= hit_s0;
      end
   end

   // Stage 1: cell word has arrived; address the font ROM.
   assign codepoint = cell_data[CODE_LSB +: CP_W];
   assign glyph_row = row_s1_reg;

   logic [FC_W-1:0]    col_s2_reg;
   logic [GR_W-1:0]    row_s2_reg;
   logic [COLOR_W-1:0] fg_s2_reg, bg_s2_reg;
   logic               active_s2_reg, hsync_s2_reg, vsync_s2_reg, hit_s2_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col_s2_reg    <= '0;
         row_s2_reg    <= '0;
         fg_s2_reg     <= '0;
         bg_s2_reg     <= '0;
         active_s2_reg <= 1'b0;
         hsync_s2_reg  <= 1'b0;
         vsync_s2_reg  <= 1'b0;
         hit_s2_reg    <= 1'b0;
      end else begin
         col_s2_reg    <= col_s1_reg;
         row_s2_reg    <= row_s1_reg;
         fg_s2_reg     <= cell_data[FG_LSB +: COLOR_W];
         bg_s2_reg     <= cell_data[BG_LSB +: COLOR_W];
         active_s2_reg <= active_s1_reg;
         hsync_s2_reg  <= hsync_s1_reg;
         vsync_s2_reg  <= vsync_s1_reg;
         hit_s2_reg    <= hit_s1_reg;
      end
   end

   // Stage 2: mirror the ROM row so index 0 is the leftmost (MSB) pixel.
   logic [FONT_WIDTH-1:0] glyph_bits;

   generate
      for (genvar gi = 0; gi < FONT_WIDTH; gi++) begin : g_mirror
         assign glyph_bits[gi] = bitmap_row[FONT_WIDTH-1-gi];
      end
   endgenerate

   logic               cursor_inv;
   logic               pix_bit;
   logic [COLOR_W-1:0] pixel_next;

   assign cursor_inv = hit_s2_reg && (row_s2_reg >= GR_W'(CURSOR_START));
   assign pix_bit    = glyph_bits[col_s2_reg] ^ cursor_inv;
   assign pixel_next = (active_s2_reg && enable) ? (pix_bit ? fg_s2_reg : bg_s2_reg) : '0;

   logic [COLOR_W-1:0] pixel_reg;
   logic               active_out_reg, hsync_out_reg, vsync_out_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pixel_reg      <= '0;
         active_out_reg <= 1'b0;
         hsync_out_reg  <= 1'b0;
         vsync_out_reg  <= 1'b0;
      end else begin
         pixel_reg      <= pixel_next;
         active_out_reg <= active_s2_reg;
         hsync_out_reg  <= hsync_s2_reg;
         vsync_out_reg  <= vsync_s2_reg;
      end
   end

   assign pixel      = pixel_reg;
   assign active_out = active_out_reg;
   assign hsync_out  = hsync_out_reg;
   assign vsync_out  = vsync_out_reg;

endmodule

// File: tb/tb_text_mode_ctrl.sv
// Directed bench for text_mode_ctrl with behavioural text buffer and font ROM.
module tb_text_mode_ctrl;
   import text_mode_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [9:0]  hcount, vcount;
   logic        active_in, hsync_in, vsync_in;
   logic        enable, cursor_en;
   logic [6:0]  cursor_col;
   logic [4:0]  cursor_row;
   logic [11:0] cell_addr;
   logic [15:0] cell_data;
   logic [7:0]  codepoint;
   logic [3:0]  glyph_row;
   logic [7:0]  bitmap_row;
   logic [3:0]  pixel;
   logic        active_out, hsync_out, vsync_out;

   int checks = 0;
   int errors = 0;

   logic [15:0] text_mem [0:4095];
   logic [7:0]  font_mem [0:4095];

   text_mode_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .hcount     (hcount),
      .vcount     (vcount),
      .active_in  (active_in),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .enable     (enable),
      .cursor_en  (cursor_en),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .cell_addr  (cell_addr),
      .cell_data  (cell_data),
      .codepoint  (codepoint),
      .glyph_row  (glyph_row),
      .bitmap_row (bitmap_row),
      .pixel      (pixel),
      .active_out (active_out),
      .hsync_out  (hsync_out),
      .vsync_out  (vsync_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memories with one-cycle read latency.
   always @(posedge clk) begin
      cell_data  <= text_mem[cell_addr];
      bitmap_row <= font_mem[{codepoint, glyph_row}];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive n pixels from (h0, v) and check each colour three clocks later.
   task automatic pix_seq(input string tag, input int h0, input int v, input int n,
                          input logic [31:0] exp);
      $display("seq  %s x=%0d y=%0d n=%0d", tag, h0, v, n);
      for (int i = 0; i < n + 2; i++) begin
         if (i < n) begin
            hcount = 10'(h0 + i); vcount = 10'(v); active_in = 1'b1;
         end else begin
            hcount = '0; vcount = '0; active_in = 1'b0;
         end
         tick();
         if (i >= 2) begin
            check({tag, "_pix"}, pixel, exp[4*(i-2) +: 4]);
            check({tag, "_act"}, active_out, 1);
         end
      end
   endtask

   task automatic vs_pulse();
      vsync_in = 1'b1; tick(); tick();
      vsync_in = 1'b0; tick();
   endtask

   initial begin
      cell_t       c;
      logic [7:0]  hs_pat;
      logic [7:0]  vs_pat;

      for (int i = 0; i < 4096; i++) begin
         c.bg = 4'h1; c.fg = 4'hF; c.code = 8'h20;
         text_mem[i] = c;
         font_mem[i] = 8'h00;
      end
      c.code = 8'h41;
      text_mem[0] = c;
      font_mem[{8'h41, 4'd5}] = 8'h66;

      rst_n = 1'b0; enable = 1'b1; cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
      hcount = '0; vcount = '0; active_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
      tick();

      // Reset held while counters run.
      for (int i = 0; i < 5; i++) begin
         hcount = 10'(i); vcount = 10'd5; active_in = 1'b1; hsync_in = i[0];
         tick();
         check("rst_pixel", pixel, 0);
         check("rst_active", active_out, 0);
         check("rst_hsync", hsync_out, 0);
         check("rst_vsync", vsync_out, 0);
      end

      // Release: first valid pixel exactly three clocks later.
      rst_n = 1'b1; hsync_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         hcount = 10'd0; vcount = 10'd5; active_in = 1'b1;
         tick();
         if (i == 0) begin
            check("cp_code", codepoint, 8'h41);
            check("cp_row", glyph_row, 5);
         end
         check("rel_active", active_out, (i == 2));
      end
      check("rel_pixel", pixel, 1);

      pix_seq("glyph_A", 0, 5, 8, 32'h1FF11FF1);

      // Addressing and clamp.
      hcount = 10'd639; vcount = 10'd479; active_in = 1'b1; #1;
      check("addr_last", cell_addr, 2399);
      hcount = 10'd16; vcount = 10'd16; #1;
      check("addr_82", cell_addr, 82);
      hcount = 10'd700; vcount = 10'd100; active_in = 1'b0; #1;
      check("addr_clamp", cell_addr, 0);
      tick(); tick(); tick();
      check("clamp_pixel", pixel, 0);
      check("clamp_active", active_out, 0);

      // Cursor on a space cell at column 2, row 1.
      cursor_en = 1'b1; cursor_col = 7'd2; cursor_row = 5'd1;
      pix_seq("cur_r30", 16, 30, 8, 32'hFFFFFFFF);
      pix_seq("cur_r31", 16, 31, 8, 32'hFFFFFFFF);
      pix_seq("cur_r29", 16, 29, 8, 32'h11111111);
      pix_seq("cur_next", 24, 30, 1, 32'h1);
      cursor_col = 7'd80;
      pix_seq("cur_oob", 16, 30, 1, 32'h1);
      cursor_col = 7'd2;

      // Blink: 31 edges keep it, the 32nd hides it.
      repeat (31) vs_pulse();
      pix_seq("blink31", 16, 30, 8, 32'hFFFFFFFF);
      vs_pulse();
      pix_seq("blink32", 16, 30, 8, 32'h11111111);
      vsync_in = 1'b1;
      repeat (50) tick();
      vsync_in = 1'b0;
      tick();
      repeat (30) vs_pulse();
      pix_seq("blink_held", 16, 30, 8, 32'h11111111);
      vs_pulse();
      pix_seq("blink_back", 16, 30, 8, 32'hFFFFFFFF);

      // Enable off: pixel forced to 0, syncs still delayed by three clocks.
      enable = 1'b0;
      hs_pat = 8'b10110010;
      vs_pat = 8'b01100100;
      $display("seq  enable_off syncs");
      for (int i = 0; i < 10; i++) begin
         if (i < 8) begin
            hcount = 10'(i); vcount = 10'd5; active_in = 1'b1;
            hsync_in = hs_pat[i]; vsync_in = vs_pat[i];
         end else begin
            hcount = '0; vcount = '0; active_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
         end
         tick();
         if (i >= 2) begin
            check("en0_pixel", pixel, 0);
            check("en0_hsync", hsync_out, hs_pat[i-2]);
            check("en0_vsync", vsync_out, vs_pat[i-2]);
         end
      end
      enable = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/text_mode_ctrl.md
Name: text_mode_ctrl

Overview:
Sequences the synchronous font ROM and the text-cell buffer BRAM to turn raster counters from the video timing generator into a per-pixel 4-bit colour index. Each pixel runs through a fixed 3-stage pipeline: cell fetch, glyph-row fetch, then bit select with attribute colour. Sync and blank signals are delayed to match the pipeline. The block also owns the hardware cursor: position, frame-based blink, and glyph inversion.

Parameters:
FONT_WIDTH, 8, glyph width in pixels (power of 2)
FONT_HEIGHT, 16, glyph height in rows (power of 2)
N_CHARS, 256, glyph count; codepoint width = $clog2(N_CHARS)
COLS, 80, text columns
ROWS, 30, text rows
HW, 10, width of hcount/vcount
BLINK_FRAMES, 32, frames per cursor blink half-period
CURSOR_START, 14, first glyph row drawn as cursor (through FONT_HEIGHT-1)

Ports:
clk  in  1  pixel clock
rst_n  in  1  synchronous reset, active low
hcount  in  HW  current pixel x
vcount  in  HW  current pixel y
active_in  in  1  visible-area flag
hsync_in  in  1  hsync from timing generator
vsync_in  in  1  vsync from timing generator, active high
enable  in  1  0 = force colour 0 for all pixels
cursor_en  in  1  cursor visible when 1
cursor_col  in  $clog2(COLS)  cursor column
cursor_row  in  $clog2(ROWS)  cursor row
cell_addr  out  $clog2(COLS*ROWS)  text buffer read address (combinational)
cell_data  in  16  buffer data, valid 1 cycle after cell_addr; [7:0] code, [11:8] fg, [15:12] bg
codepoint  out  $clog2(N_CHARS)  font ROM codepoint
glyph_row  out  $clog2(FONT_HEIGHT)  font ROM row
bitmap_row  in  FONT_WIDTH  font ROM data, valid 1 cycle after codepoint/glyph_row
pixel  out  4  colour index
active_out, hsync_out, vsync_out  out  1 each  inputs delayed 3 cycles

Behaviour:
- Reset (rst_n low at a clk edge): all pipeline registers 0; pixel, active_out, hsync_out, vsync_out = 0; blink counter 0; blink phase 0 (cursor shown). Reset mid-frame discards in-flight pixels. Outputs are valid from the 4th cycle after release.
- Stage 0 (cycle T):
  - cell_addr = (vcount/FONT_HEIGHT)*COLS + hcount/FONT_WIDTH.
  - Register hcount%FONT_WIDTH, vcount%FONT_HEIGHT, active_in, syncs, and the cursor-hit flag (cell == cursor_col/cursor_row).
  - While active_in=0, cell_addr is clamped to 0 so out-of-range counters never address past COLS*ROWS-1.
- Stage 1 (T+1): codepoint = cell_data[7:0] (truncated to the codepoint width); glyph_row = registered row. Register fg, bg and the stage-0 sidebands.
- Stage 2 (T+2): bit = bitmap_row[FONT_WIDTH-1 - col]; MSB is the leftmost pixel.
- Cursor inversion: bit is inverted if cursor_en && hit && blink phase = 0 && glyph row >= CURSOR_START.
- Pixel (registered at T+3): pixel = bit ? fg : bg. pixel is forced to 0 if active=0 or enable=0. Latency is exactly 3 clocks, input to pixel/sync outputs.
- Blink counter:
  - Increments on each vsync_in rising edge (edge detected against the previous sample).
  - When it reaches BLINK_FRAMES-1 and another edge arrives, it wraps to 0 and the blink phase toggles.
- Cursor inputs are sampled in stage 0 only. A change mid-frame takes effect from the next pixel processed.
- cursor_col >= COLS or cursor_row >= ROWS never hits, so no cursor is drawn.
- No stall path: the pipeline advances every clock unconditionally.

Decomposition:
- Package text_mode_pkg: cell field offsets (CODE_LSB=0, FG_LSB=8, BG_LSB=12), a packed cell_t typedef, and localparams for the derived widths.
- Sub-module cursor_blink: vsync edge detect, frame counter and phase output.
- The pipeline stays in text_mode_ctrl; fontROM is instantiated by the parent with ASYNC=0.

Test Plan:
- Reset: hold rst_n=0 for 5 clks while counters run -> pixel=0 and all sync outputs 0; first valid pixel appears 3 clks after release.
- Glyph fetch: cell 0 = 0x1F41 (code 'A', fg 15, bg 1); ROM row 5 of 'A' = 0x66; hcount 0..7, vcount 5 -> cell_addr 0 and codepoint 0x41 with glyph_row 5 seen a cycle later; pixel sequence 1,15,15,1,1,15,15,1 starting 3 clks later.
- Addressing and clamp: hcount=639, vcount=479 -> cell_addr=2399; active_in=0 with hcount=700 -> cell_addr=0 and pixel=0.
- Cursor: cursor at (col 2, row 1), cursor_en=1, phase 0, cell holds a space (ROM row 0x00) -> rows 30,31 at x 16..23 output fg; row 29 outputs bg.
- Blink: 32 vsync rising edges -> phase toggles and the cursor disappears; 32 more edges -> it reappears; a vsync held high for many clocks counts once.
- Enable/sync alignment: enable=0 -> pixel=0 while hsync_out/vsync_out still track the inputs with 3-clk delay.
